// File: rtl/apb_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : apb_cmd_master
// Purpose  : valid/ready command stream -> APB3 SETUP/ACCESS initiator with a
//            one-cycle response. Define APB_PREADY_EN for wait states + timeout.
// Revision : 1.0
// ============================================================================
module apb_cmd_master #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst_,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   output logic              rsp_write,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              busy,
   output logic [ADDR_W-1:0] paddr_o,
   output logic [DATA_W-1:0] pwdata_o,
   output logic              pwrite_o,
   output logic              psel_o,
   output logic              penable_o,
   input  logic [DATA_W-1:0] prdata_i,
   input  logic              pready_i
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] paddr_q, paddr_d;
   logic [DATA_W-1:0] pwdata_q, pwdata_d;
   logic              pwrite_q, pwrite_d;
   logic              psel_q, psel_d;
   logic              penable_q, penable_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_write_q, rsp_write_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

   logic              done;
   logic              abort;
   logic              handshake;
   logic [1:0]        unused_addr_lsb;

   assign unused_addr_lsb = cmd_addr[1:0];

`ifdef APB_PREADY_EN
   localparam int               CNT_W    = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic             rsp_err_q, rsp_err_d;

   assign done  = (state_q == ACCESS) && pready_i;
   // abort on the wait cycle that would bring the counter to TIMEOUT
   assign abort = (state_q == ACCESS) && !pready_i && (wait_cnt_q == CNT_LAST);

   always_comb begin
      wait_cnt_d = wait_cnt_q;
      rsp_err_d  = abort;
      if (state_q == SETUP) begin
         wait_cnt_d = '0;
      end else if ((state_q == ACCESS) && !pready_i) begin
         wait_cnt_d = wait_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         wait_cnt_q <= '0;
         rsp_err_q  <= 1'b0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
         rsp_err_q  <= rsp_err_d;
      end
   end

   assign rsp_err = rsp_err_q;
`else
   logic unused_pready;

   assign unused_pready = pready_i;
   assign done          = (state_q == ACCESS);
   assign abort         = 1'b0;
   assign rsp_err       = 1'b0;
`endif

   assign cmd_ready = (state_q == IDLE) || done;
   assign handshake = cmd_valid && cmd_ready;

   always_comb begin
      state_d     = state_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      pwrite_d    = pwrite_q;
      psel_d      = psel_q;
      penable_d   = penable_q;
      rsp_valid_d = 1'b0;
      rsp_write_d = rsp_write_q;
      rsp_rdata_d = rsp_rdata_q;

      if (handshake) begin
         // slave decodes word addresses only
         paddr_d  = {cmd_addr[ADDR_W-1:2], 2'b00};
         pwdata_d = cmd_wdata;
         pwrite_d = cmd_write;
      end

      case (state_q)
         IDLE: begin
            if (handshake) begin
               state_d   = SETUP;
               psel_d    = 1'b1;
               penable_d = 1'b0;
            end
         end
         SETUP: begin
            state_d   = ACCESS;
            penable_d = 1'b1;
         end
         ACCESS: begin
            if (done || abort) begin
               rsp_valid_d = 1'b1;
               rsp_write_d = pwrite_q;
               if (abort) begin
                  rsp_rdata_d = '0;
               end else if (!pwrite_q) begin
                  rsp_rdata_d = prdata_i;
               end
               if (handshake) begin
                  state_d   = SETUP;
                  psel_d    = 1'b1;
                  penable_d = 1'b0;
               end else begin
                  state_d   = IDLE;
                  psel_d    = 1'b0;
                  penable_d = 1'b0;
               end
            end
         end
         default: begin
            state_d   = IDLE;
            psel_d    = 1'b0;
            penable_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state_q     <= IDLE;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         pwrite_q    <= 1'b0;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_write_q <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         pwrite_q    <= pwrite_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_write_q <= rsp_write_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   assign busy      = (state_q != IDLE);
   assign paddr_o   = paddr_q;
   assign pwdata_o  = pwdata_q;
   assign pwrite_o  = pwrite_q;
   assign psel_o    = psel_q;
   assign penable_o = penable_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_write = rsp_write_q;
   assign rsp_rdata = rsp_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_cmd_master
// Purpose  : random and directed command traffic into apb_cmd_master driving a
//            word-addressed APB slave, checked against an in-order reference.
// Revision : 1.0
// ============================================================================
module tb_apb_cmd_master;

   logic        clk = 1'b0;
   logic        rst_ = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_write = 1'b0;
   logic [31:0] cmd_addr = '0;
   logic [31:0] cmd_wdata = '0;
   logic        rsp_valid, rsp_write, rsp_err, busy;
   logic [31:0] rsp_rdata;
   logic [31:0] paddr_o, pwdata_o, prdata_i;
   logic        pwrite_o, psel_o, penable_o;
   logic        pready_i = 1'b1;

   always #5 clk = ~clk;

   apb_cmd_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(15)) dut (
      .clk(clk), .rst_(rst_),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .busy(busy),
      .paddr_o(paddr_o), .pwdata_o(pwdata_o), .pwrite_o(pwrite_o),
      .psel_o(psel_o), .penable_o(penable_o),
      .prdata_i(prdata_i), .pready_i(pready_i)
   );

   // APB slave: 16 word registers
   logic [31:0] slave_mem [16];
   assign prdata_i = slave_mem[paddr_o[5:2]];
   always @(posedge clk)
      if (psel_o && penable_o && pwrite_o && pready_i)
         slave_mem[paddr_o[5:2]] <= pwdata_o;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic        w;
      logic [31:0] d;
      logic        e;
      int          c;
   } rsp_t;

   rsp_t obs_q[$];
   rsp_t exp_q[$];
   logic ps_log [4096];
   logic pe_log [4096];
   logic rdy_log[4096];

   always @(negedge clk) begin
      if (cyc < 4096) begin
         ps_log[cyc]  = psel_o;
         pe_log[cyc]  = penable_o;
         rdy_log[cyc] = cmd_ready;
      end
      if (rsp_valid) obs_q.push_back('{rsp_write, rsp_rdata, rsp_err, cyc});
   end

   // transaction-level reference: register file and last read value
   logic [31:0] ref_mem [16];
   logic [31:0] ref_rdata = '0;

   int vectors = 0;
   int miscompares = 0;

   // Returns at the negedge of the cycle following the handshake; hs is the
   // cycle index in which the handshake took place.
   task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d,
                        output int hs);
      int n = 0;
      cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
      while (!cmd_ready && n < 64) begin
         @(negedge clk);
         n++;
      end
      vectors++;
      if (n >= 64) begin
         miscompares++;
         $display("FAIL cmd_ready_wait: ready=%b after %0d cycles, want 1", cmd_ready, n);
      end
      @(posedge clk);
      hs = cyc;
      if (w) ref_mem[a[5:2]] = d;
      else   ref_rdata = ref_mem[a[5:2]];
      exp_q.push_back('{w, ref_rdata, 1'b0, hs});
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_write = 1'($urandom_range(0, 1));
      cmd_addr  = $urandom;
      cmd_wdata = $urandom;
   endtask

   task automatic wait_obs(input int n, output bit ok);
      int t = 0;
      while (obs_q.size() < n && t < 200) begin
         @(negedge clk);
         t++;
      end
      ok = (obs_q.size() >= n);
   endtask

   task automatic test_reset();
      rst_ = 1'b0;
      repeat (2) @(negedge clk);
      vectors++;
      if ({psel_o, penable_o, pwrite_o, rsp_valid, rsp_write, rsp_err, busy, cmd_ready} !== 8'b0000_0001) begin
         miscompares++;
         $display("FAIL reset_ctrl: got %b want 00000001",
                  {psel_o, penable_o, pwrite_o, rsp_valid, rsp_write, rsp_err, busy, cmd_ready});
      end
      vectors++;
      if (paddr_o !== 32'h0 || pwdata_o !== 32'h0 || rsp_rdata !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_data: paddr=%h pwdata=%h rdata=%h want all 0", paddr_o, pwdata_o, rsp_rdata);
      end
      rst_ = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_read_after_reset();
      int h; bit ok; rsp_t o, x;
      drive(1'b0, 32'h0C, $urandom, h);
      wait_obs(1, ok);
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL rd0c_rsp: no response, want 1");
      end else begin
         o = obs_q.pop_front(); x = exp_q.pop_front();
         vectors++;
         if (o.d !== 32'h34 || o.w !== 1'b0 || o.e !== 1'b0 || o.c != x.c + 3) begin
            miscompares++;
            $display("FAIL rd0c: got w=%b d=%h e=%b lat=%0d want w=0 d=00000034 e=0 lat=3",
                     o.w, o.d, o.e, o.c - x.c);
         end
      end
   endtask

   task automatic test_write_read();
      int h; bit ok; rsp_t o, x;
      drive(1'b1, 32'h08, 32'h180, h);
      vectors++;
      if ({psel_o, penable_o, pwrite_o} !== 3'b101 || paddr_o !== 32'h08) begin
         miscompares++;
         $display("FAIL wr_setup: sel/en/wr=%b addr=%h want 101 addr=00000008",
                  {psel_o, penable_o, pwrite_o}, paddr_o);
      end
      @(negedge clk);
      vectors++;
      if ({psel_o, penable_o} !== 2'b11) begin
         miscompares++;
         $display("FAIL wr_access: sel/en=%b want 11", {psel_o, penable_o});
      end
      drive(1'b0, 32'h08, 32'h0, h);
      wait_obs(2, ok);
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL wr_rd_rsp: got %0d responses want 2", obs_q.size());
      end else begin
         o = obs_q.pop_front(); x = exp_q.pop_front();
         vectors++;
         if (o.w !== 1'b1 || o.e !== 1'b0 || o.d !== x.d || o.c != x.c + 3) begin
            miscompares++;
            $display("FAIL wr_rsp: got w=%b e=%b d=%h lat=%0d want w=1 e=0 d=%h lat=3",
                     o.w, o.e, o.d, o.c - x.c, x.d);
         end
         o = obs_q.pop_front(); x = exp_q.pop_front();
         vectors++;
         if (o.w !== 1'b0 || o.d !== 32'h180 || o.e !== 1'b0) begin
            miscompares++;
            $display("FAIL rd08: got w=%b d=%h e=%b want w=0 d=00000180 e=0", o.w, o.d, o.e);
         end
      end
   endtask

   task automatic test_back_to_back();
      int h0, h1, h2; bit ok; rsp_t o, x;
      drive(1'b1, 32'h00, 32'h0000_0003, h0);
      drive(1'b1, 32'h18, 32'h0000_00C7, h1);
      drive(1'b1, 32'h10, 32'h0000_0001, h2);
      wait_obs(3, ok);
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL b2b_rsp: got %0d responses want 3", obs_q.size());
      end
      for (int i = 0; i < 6; i++) begin
         vectors++;
         if (ps_log[h0+1+i] !== 1'b1 || pe_log[h0+1+i] !== 1'(i % 2) || rdy_log[h0+1+i] !== 1'(i % 2)) begin
            miscompares++;
            $display("FAIL b2b_phase%0d: sel/en/rdy=%b%b%b want 1%0d%0d",
                     i, ps_log[h0+1+i], pe_log[h0+1+i], rdy_log[h0+1+i], i % 2, i % 2);
         end
      end
      vectors++;
      if (ps_log[h0+7] !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_end: psel=%b want 0", ps_log[h0+7]);
      end
      for (int i = 0; i < 3 && obs_q.size() > 0; i++) begin
         o = obs_q.pop_front(); x = exp_q.pop_front();
         vectors++;
         if (o.w !== 1'b1 || o.e !== 1'b0 || o.d !== x.d || o.c != h0 + 3 + 2 * i) begin
            miscompares++;
            $display("FAIL b2b_rsp%0d: got w=%b e=%b d=%h cyc=%0d want w=1 e=0 d=%h cyc=%0d",
                     i, o.w, o.e, o.d, o.c, x.d, h0 + 3 + 2 * i);
         end
      end
   endtask

   task automatic test_addr_align();
      int h; bit ok; rsp_t o, x;
      drive(1'b0, 32'h0000_001F, 32'h0, h);
      vectors++;
      if (paddr_o !== 32'h0000_001C || pwrite_o !== 1'b0) begin
         miscompares++;
         $display("FAIL align: paddr=%h wr=%b want 0000001c wr=0", paddr_o, pwrite_o);
      end
      wait_obs(1, ok);
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL align_rsp: no response, want 1");
      end else begin
         o = obs_q.pop_front(); x = exp_q.pop_front();
         vectors++;
         if (o.d !== x.d || o.w !== 1'b0) begin
            miscompares++;
            $display("FAIL align_rd: got d=%h w=%b want d=%h w=0", o.d, o.w, x.d);
         end
      end
   endtask

   task automatic test_random();
      int h; bit ok; rsp_t o, x; logic w; logic [31:0] a, d;
      for (int k = 0; k < 60; k++) begin
         w = 1'($urandom_range(0, 1)); a = $urandom; d = $urandom;
         drive(w, a, d, h);
         vectors++;
         if (paddr_o !== (a & 32'hFFFF_FFFC) || pwrite_o !== w || pwdata_o !== d ||
             psel_o !== 1'b1 || penable_o !== 1'b0) begin
            miscompares++;
            $display("FAIL rnd_setup%0d: addr=%h wr=%b wd=%h sel/en=%b%b want addr=%h wr=%b wd=%h sel/en=10",
                     k, paddr_o, pwrite_o, pwdata_o, psel_o, penable_o, a & 32'hFFFF_FFFC, w, d);
         end
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      wait_obs(exp_q.size(), ok);
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL rnd_count: got %0d responses want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         o = obs_q.pop_front(); x = exp_q.pop_front();
         vectors++;
         if (o.w !== x.w || o.d !== x.d || o.e !== 1'b0 || o.c != x.c + 3) begin
            miscompares++;
            $display("FAIL rnd_rsp: got w=%b d=%h e=%b lat=%0d want w=%b d=%h e=0 lat=3",
                     o.w, o.d, o.e, o.c - x.c, x.w, x.d);
         end
      end
      exp_q.delete();
   endtask

   task automatic test_reset_mid();
      int h, n0;
      drive(1'b0, 32'h04, 32'h0, h);
      @(negedge clk);
      vectors++;
      if (penable_o !== 1'b1) begin
         miscompares++;
         $display("FAIL rstmid_pre: penable=%b want 1", penable_o);
      end
      n0 = obs_q.size();
      #2 rst_ = 1'b0;
      #1;
      vectors++;
      if ({psel_o, penable_o} !== 2'b00) begin
         miscompares++;
         $display("FAIL rstmid_async: sel/en=%b want 00", {psel_o, penable_o});
      end
      void'(exp_q.pop_back());
      ref_rdata = '0;
      repeat (2) @(negedge clk);
      rst_ = 1'b1;
      repeat (4) @(negedge clk);
      vectors++;
      if (obs_q.size() != n0) begin
         miscompares++;
         $display("FAIL rstmid_rsp: got %0d responses want %0d", obs_q.size(), n0);
      end
      vectors++;
      if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL rstmid_idle: busy=%b ready=%b want busy=0 ready=1", busy, cmd_ready);
      end
   endtask

`ifdef APB_PREADY_EN
   task automatic test_pready();
      int h, n; bit ok; rsp_t o, x;
      drive(1'b0, 32'h0C, 32'h0, h);
      pready_i = 1'b0;
      repeat (4) @(negedge clk);
      pready_i = 1'b1;
      wait_obs(1, ok);
      repeat (6) @(negedge clk);
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL wait_rsp: no response, want 1");
      end else begin
         o = obs_q.pop_front(); x = exp_q.pop_front();
         vectors++;
         if (o.d !== x.d || o.e !== 1'b0 || o.c != h + 6) begin
            miscompares++;
            $display("FAIL wait_rd: got d=%h e=%b cyc=%0d want d=%h e=0 cyc=%0d", o.d, o.e, o.c, x.d, h + 6);
         end
      end
      n = 0;
      for (int i = 1; i < 12; i++) n += int'(pe_log[h+i]);
      vectors++;
      if (n != 4) begin
         miscompares++;
         $display("FAIL wait_penable: got %0d cycles want 4", n);
      end

      drive(1'b0, 32'h08, 32'h0, h);
      pready_i = 1'b0;
      wait_obs(1, ok);
      pready_i = 1'b1;
      repeat (3) @(negedge clk);
      void'(exp_q.pop_back());
      ref_rdata = '0;
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL tmo_rsp: no response, want 1");
      end else begin
         o = obs_q.pop_front();
         vectors++;
         if (o.e !== 1'b1 || o.d !== 32'h0 || o.w !== 1'b0 || o.c != h + 17) begin
            miscompares++;
            $display("FAIL tmo: got e=%b d=%h w=%b cyc=%0d want e=1 d=00000000 w=0 cyc=%0d",
                     o.e, o.d, o.w, o.c, h + 17);
         end
      end
      n = 0;
      for (int i = 1; i < 20; i++) n += int'(pe_log[h+i]);
      vectors++;
      if (n != 15 || rdy_log[h+16] !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL tmo_shape: penable=%0d abort_rdy=%b busy=%b want 15 0 0", n, rdy_log[h+16], busy);
      end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 16; i++) begin
         slave_mem[i] = 32'hA500_0000 + 32'(i) * 32'h0001_0101;
         ref_mem[i]   = 32'hA500_0000 + 32'(i) * 32'h0001_0101;
      end
      slave_mem[3] = 32'h34;
      ref_mem[3]   = 32'h34;

      test_reset();
      test_read_after_reset();
      test_write_read();
      test_back_to_back();
      test_addr_align();
      test_random();
      test_reset_mid();
`ifdef APB_PREADY_EN
      test_pready();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
